// File: rtl/instr_buffer_ctrl.sv
// ============================================================================
// Module      : instr_buffer_ctrl
// Description : Load-then-run sequencer for a single-port instruction buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_buffer_ctrl #(
    parameter  int IW   = 16,
    parameter  int BS   = 16,
    localparam int IDXW = $clog2(BS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic              ld_valid,
    input  logic [IW-1:0]     ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              buf_we,
    output logic [IDXW-1:0]   buf_index,
    output logic [IW-1:0]     buf_wdata,
    input  logic [IW-1:0]     buf_rdata,
    output logic              issue_valid,
    output logic [IW-1:0]     issue_data,
    output logic [IDXW-1:0]   issue_index,
    input  logic              issue_ready,
    input  logic              jump_valid,
    input  logic [IDXW-1:0]   jump_index,
    output logic [IDXW:0]     loaded_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_MAX = IDXW'(BS - 1);
    localparam logic [IDXW:0]   CNT_ONE = (IDXW + 1)'(1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDXW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [IDXW:0]     loaded_count_q, loaded_count_d;

    logic              ld_ready_q;
    logic              issue_valid_q;
    logic [IDXW-1:0]   issue_index_q;
    logic              busy_q;
    logic              done_q;

    logic              ld_fire;
    logic              issue_fire;
    logic              wr_full;
    logic              rd_last;
    logic              jump_in_range;

    // ld_ready_q / issue_valid_q are exact images of the state, so they
    // double as the handshake qualifiers.
    assign ld_fire       = ld_valid & ld_ready_q;
    assign issue_fire    = issue_valid_q & issue_ready;
    assign wr_full       = (wr_ptr_q == IDX_MAX);
    assign rd_last       = (({1'b0, rd_ptr_q} + CNT_ONE) == loaded_count_q);
    assign jump_in_range = ({1'b0, jump_index} < loaded_count_q);

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        loaded_count_d = loaded_count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_LOAD;
                    wr_ptr_d       = '0;
                    rd_ptr_d       = '0;
                    loaded_count_d = '0;
                end
            end

            S_LOAD: begin
                if (ld_fire) begin
                    loaded_count_d = loaded_count_q + CNT_ONE;
                    // Hold the pointer on the final slot so it never wraps.
                    if (!wr_full) begin
                        wr_ptr_d = wr_ptr_q + IDX_ONE;
                    end
                    if (ld_last || wr_full) begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                state_d = S_ISSUE;
            end

            S_ISSUE: begin
                if (issue_fire) begin
                    if (jump_valid) begin
                        if (jump_in_range) begin
                            rd_ptr_d = jump_index;
                            state_d  = S_FETCH;
                        end else begin
                            state_d  = S_DONE;
                        end
                    end else if (rd_last) begin
                        state_d = S_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + IDX_ONE;
                        state_d  = S_FETCH;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            loaded_count_q <= '0;
            ld_ready_q     <= 1'b0;
            issue_valid_q  <= 1'b0;
            issue_index_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            loaded_count_q <= loaded_count_d;
            ld_ready_q     <= (state_d == S_LOAD);
            issue_valid_q  <= (state_d == S_ISSUE);
            issue_index_q  <= (state_d == S_ISSUE) ? rd_ptr_d : '0;
            busy_q         <= (state_d == S_LOAD) || (state_d == S_FETCH) ||
                              (state_d == S_ISSUE);
            done_q         <= (state_d == S_DONE);
        end
    end

    // The buffer read is registered, so issue_data stays stable while the
    // index is held during a decoder stall.
    assign ld_ready     = ld_ready_q;
    assign buf_we       = ld_fire;
    assign buf_index    = (state_q == S_LOAD) ? wr_ptr_q : rd_ptr_q;
    assign buf_wdata    = ld_fire ? ld_data : '0;
    assign issue_valid  = issue_valid_q;
    assign issue_data   = issue_valid_q ? buf_rdata : '0;
    assign issue_index  = issue_index_q;
    assign loaded_count = loaded_count_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

`default_nettype wire
